regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  - LEGv8 integer register file: 32 x 64-bit, two read ports, one write port.
//  - Sits directly upstream of the ALU-operand 2:1 mux.
//  - rd2 drives the mux in0 (register operand); the sign-extended immediate drives in1.
//  - rd1 drives ALU operand A. Writeback data arrives on the write port.
//  - X31 is XZR: reads as zero, and writes to it are discarded.
// PARAMETERS
//  DATA_W    64  register / data width in bits
//  ADDR_W     5  register address width
//  NUM_REGS  32  implemented registers, addresses 0..NUM_REGS-1
//  ZERO_REG  31  hard-wired zero register index
//  BYPASS     1  1 = same-cycle write data forwarded to reads; 0 = reads return old data
// PORTS
//  clk       in   1       clock, all state updates on rising edge
//  rst_n     in   1       synchronous reset, active-low
//  rd_en     in   1       capture read ports this cycle
//  ra1       in   ADDR_W  read address, port 1
//  ra2       in   ADDR_W  read address, port 2
//  wr_en     in   1       write enable
//  wa        in   ADDR_W  write address
//  wd        in   DATA_W  write data
//  rd1       out  DATA_W  registered read data, port 1 (ALU operand A)
//  rd2       out  DATA_W  registered read data, port 2 (to mux in0)
//  rd_valid  out  1       rd1/rd2 updated by the previous cycle's rd_en
// BEHAVIOUR
//  Reset:
//   - rst_n=0 at a posedge: all registers <= 0, rd1 <= 0, rd2 <= 0, rd_valid <= 0.
//   - Reset overrides wr_en and rd_en in the same cycle; no write takes effect.
//   - Reset mid-stream discards any pending read; rd_valid is 0 the following cycle.
//  Write:
//   - At a posedge with wr_en=1: regs[wa] <= wd.
//   - Suppressed when wa==ZERO_REG or wa>=NUM_REGS.
//   - No partial writes; full DATA_W is stored.
//  Read:
//   - At a posedge with rd_en=1: rd1 <= val(ra1), rd2 <= val(ra2), rd_valid <= 1.
//   - Read latency is exactly 1 cycle.
//   - rd_en=0: rd1 and rd2 hold their previous values; rd_valid <= 0.
//  val(a):
//   - a==ZERO_REG or a>=NUM_REGS -> 0.
//   - Else if BYPASS=1, wr_en=1 and wa==a -> wd (write-first).
//   - Else -> regs[a] as held before the edge (read-first).
//   - Bypass never applies to ZERO_REG: a write of wd to X31 still reads 0.
//  Simultaneous events:
//   - ra1==ra2: both ports return the identical value.
//   - Back-to-back writes to the same register: the last one wins.
//   - A write and a read to the same register in one cycle: resolved by BYPASS as above.
//  Storage:
//   - No valid bits are kept per register.
//   - Registers never written since reset read as 0.
// TESTING
//  T1 reset: write X5=0xDEAD, then pulse rst_n low 1 cycle, then read X5 -> rd1=0, rd_valid=0 during reset.
//  T2 basic: write X3=0x0123_4567_89AB_CDEF; next cycle rd_en, ra1=3 -> rd1=0x0123456789ABCDEF after 1 cycle, rd_valid=1.
//  T3 XZR: wr_en, wa=31, wd=all-ones; read ra1=ra2=31 (same cycle and later) -> rd1=rd2=0.
//  T4 bypass: X7=0x11; same cycle wr X7=0x22 + rd_en ra2=7 -> BYPASS=1: rd2=0x22; BYPASS=0: rd2=0x11, then 0x22 next read.
//  T5 hold: rd_en=1 reading X3, then rd_en=0 for 3 cycles while writing X3=0x99 -> rd1 stays 0x0123456789ABCDEF, rd_valid=0.
//  T6 sweep: write X0..X30 with value (i<<32)|i, read all pairs (i,30-i) -> exact match on both ports.

Source files
------------

// File: rtl/regfile_2r1w.sv
// 32 x 64-bit integer register file, two registered read ports and one write port.
// X31 is hard-wired zero; same-cycle write data can be forwarded to reads when BYPASS=1.
module regfile_2r1w #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic              o_rd_valid
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_rd_valid;

    logic              w_rng_ra1;
    logic              w_rng_ra2;
    logic              w_rng_wa;
    logic              w_ok_ra1;
    logic              w_ok_ra2;
    logic              w_wr_ok;
    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_val1;
    logic [DATA_W-1:0] w_val2;

    // Range check only exists when the address space exceeds the implemented registers.
    generate
        if (NUM_REGS >= (1 << ADDR_W)) begin : g_full_range
            assign w_rng_ra1 = 1'b1;
            assign w_rng_ra2 = 1'b1;
            assign w_rng_wa  = 1'b1;
        end else begin : g_part_range
            assign w_rng_ra1 = (32'(i_ra1) < NUM_REGS);
            assign w_rng_ra2 = (32'(i_ra2) < NUM_REGS);
            assign w_rng_wa  = (32'(i_wa)  < NUM_REGS);
        end
    endgenerate

    assign w_ok_ra1 = w_rng_ra1 && (i_ra1 != ADDR_W'(ZERO_REG));
    assign w_ok_ra2 = w_rng_ra2 && (i_ra2 != ADDR_W'(ZERO_REG));
    assign w_wr_ok  = i_wr_en && w_rng_wa && (i_wa != ADDR_W'(ZERO_REG));

    // Bypass keys off the qualified write, so a write to XZR never forwards.
    assign w_byp1 = (BYPASS != 0) && w_wr_ok && (i_wa == i_ra1);
    assign w_byp2 = (BYPASS != 0) && w_wr_ok && (i_wa == i_ra2);

    always_comb begin
        w_val1 = '0;
        w_val2 = '0;
        if (w_ok_ra1) begin
            w_val1 = w_byp1 ? i_wd : r_regs[i_ra1];
        end
        if (w_ok_ra2) begin
            w_val2 = w_byp2 ? i_wd : r_regs[i_ra2];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[i_wa] <= i_wd;
            end
            if (i_rd_en) begin
                r_rd1 <= w_val1;
                r_rd2 <= w_val2;
            end
            r_rd_valid <= i_rd_en;
        end
    end

    assign o_rd1      = r_rd1;
    assign o_rd2      = r_rd2;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w (BYPASS=1): reset, basic read, XZR, bypass, hold, sweep.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        wr_en;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        rd_valid;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] V_X3 = 64'h0123_4567_89AB_CDEF;

    regfile_2r1w #(
        .DATA_W(64), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_ra1(ra1), .i_ra2(ra2),
        .i_wr_en(wr_en), .i_wa(wa), .i_wd(wd),
        .o_rd1(rd1), .o_rd2(rd2), .o_rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic rst_v, input logic we, input logic [4:0] a_w,
                        input logic [63:0] d_w, input logic re,
                        input logic [4:0] a1, input logic [4:0] a2);
        rst_n = rst_v; wr_en = we; wa = a_w; wd = d_w;
        rd_en = re; ra1 = a1; ra2 = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        n_cmp++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: rd1=%h rd2=%h valid=%b, want 0 0 0", rd1, rd2, rd_valid);
        end
        step(1'b1, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd5);
        n_cmp++;
        if (rd1 !== 64'hDEAD || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prewrite: rd1=%h valid=%b, want dead 1", rd1, rd_valid);
        end
        // Reset with pending write and read: both ignored.
        step(1'b0, 1'b1, 5'd6, 64'h77, 1'b1, 5'd5, 5'd5);
        n_cmp++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_during: rd1=%h rd2=%h valid=%b, want 0 0 0", rd1, rd2, rd_valid);
        end
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd6);
        n_cmp++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cleared: rd1=%h rd2=%h valid=%b, want 0 0 1", rd1, rd2, rd_valid);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 5'd3, V_X3, 1'b0, 5'd0, 5'd0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_novalid: valid=%b, want 0", rd_valid);
        end
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        n_cmp++;
        if (rd1 !== V_X3 || rd2 !== V_X3 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_read: rd1=%h rd2=%h valid=%b, want %h both, 1", rd1, rd2, rd_valid, V_X3);
        end
    endtask

    task automatic test_xzr();
        step(1'b1, 1'b1, 5'd31, {64{1'b1}}, 1'b1, 5'd31, 5'd31);
        n_cmp++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
            n_err++;
            $display("FAIL xzr_same: rd1=%h rd2=%h, want 0 0", rd1, rd2);
        end
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd31);
        n_cmp++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL xzr_later: rd1=%h rd2=%h valid=%b, want 0 0 1", rd1, rd2, rd_valid);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd7, 64'h22, 1'b1, 5'd3, 5'd7);
        n_cmp++;
        if (rd2 !== 64'h22 || rd1 !== V_X3) begin
            n_err++;
            $display("FAIL bypass_same: rd1=%h rd2=%h, want %h 22", rd1, rd2, V_X3);
        end
        step(1'b1, 1'b1, 5'd8, 64'h33, 1'b1, 5'd8, 5'd7);
        n_cmp++;
        if (rd1 !== 64'h33 || rd2 !== 64'h22) begin
            n_err++;
            $display("FAIL bypass_other: rd1=%h rd2=%h, want 33 22", rd1, rd2);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 5'd9, 64'h1, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd9, 64'h2, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd8);
        n_cmp++;
        if (rd1 !== 64'h2 || rd2 !== 64'h33) begin
            n_err++;
            $display("FAIL b2b_last: rd1=%h rd2=%h, want 2 33", rd1, rd2);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd9);
        n_cmp++;
        if (rd1 !== V_X3 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_start: rd1=%h valid=%b, want %h 1", rd1, rd_valid, V_X3);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 5'd3, 64'h99, 1'b0, 5'd3, 5'd3);
            n_cmp++;
            if (rd1 !== V_X3 || rd2 !== 64'h2 || rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_c%0d: rd1=%h rd2=%h valid=%b, want %h 2 0", k, rd1, rd2, rd_valid, V_X3);
            end
        end
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        n_cmp++;
        if (rd1 !== 64'h99 || rd2 !== 64'h99 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_after: rd1=%h rd2=%h valid=%b, want 99 99 1", rd1, rd2, rd_valid);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] e1;
        logic [63:0] e2;
        for (int i = 0; i <= 30; i++) begin
            step(1'b1, 1'b1, 5'(i), (64'(i) << 32) | 64'(i), 1'b0, 5'd0, 5'd0);
        end
        for (int i = 0; i <= 30; i++) begin
            step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 5'(30 - i));
            e1 = (64'(i) << 32) | 64'(i);
            e2 = (64'(30 - i) << 32) | 64'(30 - i);
            n_cmp++;
            if (rd1 !== e1 || rd2 !== e2 || rd_valid !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_%0d: rd1=%h rd2=%h valid=%b, want %h %h 1", i, rd1, rd2, rd_valid, e1, e2);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0;
        test_reset();
        test_basic();
        test_xzr();
        test_bypass();
        test_back_to_back();
        test_hold();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
